regfile_write_arbiter: RTL

// - Owns the single write port of the 32 x 32-bit register file built from reg_32_reset_enable cells.
// - Arbitrates NUM_REQ writers round-robin and decodes the winner's address into per-register writeEnable strobes.
// - Provides a sequenced clear that zeroes registers 1..31 over consecutive cycles.
// - Sits between the write-back sources (ALU, load unit, link writer) and the register array.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/rr_priority_pick.sv | 34 +++
 rtl/regfile_write_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path: geometry constants,
// the write-arbiter state encoding and the address-to-strobe decode.
package regfile_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_CLEAR = 1'b1
    } arb_state_t;

    // Register 0 is hard-wired to zero, so address 0 never produces a strobe.
    function automatic logic [REG_COUNT-1:0] reg_decode(input logic [REG_ADDR_W-1:0] addr);
        logic [REG_COUNT-1:0] onehot;
        onehot = '0;
        if (addr != '0) begin
            onehot[addr] = 1'b1;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first asserted request scanning upward from
// i_ptr with wrap-around, returned both one-hot and as an index.
module rr_priority_pick #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    int w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_pos = int'(i_ptr) + off;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            if (!o_any && i_req[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                o_idx          = ID_W'(w_pos);
                o_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single write port of the 32x32 register file: round-robin arbitration of the
// write-back sources, strobe decode, and a sequenced clear of registers 1..31.
// Optional per-requester grant counters: define REGFILE_ARB_GRANT_COUNT_EN.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2,
    parameter int DATA_W  = REG_DATA_W
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          clear_req,
    output logic                          clear_busy,
    output logic [REG_COUNT-1:0]          wr_en,
    output logic [DATA_W-1:0]             wr_data,
    output logic                          grant_valid,
    output logic [ID_W-1:0]               grant_id
`ifdef REGFILE_ARB_GRANT_COUNT_EN
    ,
    output logic [NUM_REQ*16-1:0]         grant_count
`endif
);

    localparam logic [REG_ADDR_W-1:0] CLR_FIRST = REG_ADDR_W'(1);
    localparam logic [REG_ADDR_W-1:0] CLR_LAST  = REG_ADDR_W'(REG_COUNT - 1);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [ID_W-1:0]        w_rr_ptr_nxt;
    logic [REG_ADDR_W-1:0]  r_clr_cnt;
    logic [REG_ADDR_W-1:0]  w_clr_cnt_nxt;
    logic [REG_COUNT-1:0]   r_wr_en;
    logic [REG_COUNT-1:0]   w_wr_en_nxt;
    logic [DATA_W-1:0]      r_wr_data;
    logic [DATA_W-1:0]      w_wr_data_nxt;
    logic                   r_grant_valid;
    logic                   w_grant_valid_nxt;
    logic [ID_W-1:0]        r_grant_id;
    logic [ID_W-1:0]        w_grant_id_nxt;

    logic [NUM_REQ-1:0]     w_pick_grant;
    logic [ID_W-1:0]        w_pick_idx;
    logic                   w_pick_any;
    logic                   w_arb_en;
    logic                   w_xfer;
    logic [REG_ADDR_W-1:0]  w_win_addr;
    logic [DATA_W-1:0]      w_win_data;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // A pending clear outranks every writer in the same cycle.
    assign w_arb_en  = !reset && (r_state == ARB_IDLE) && !clear_req;
    assign req_ready = w_arb_en ? w_pick_grant : '0;
    assign w_xfer    = w_arb_en && w_pick_any;

    always_comb begin
        w_win_addr = '0;
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_grant[i]) begin
                w_win_addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                w_win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ARB_IDLE;
            r_rr_ptr      <= '0;
            r_clr_cnt     <= CLR_FIRST;
            r_wr_en       <= '0;
            r_wr_data     <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_clr_cnt     <= w_clr_cnt_nxt;
            r_wr_en       <= w_wr_en_nxt;
            r_wr_data     <= w_wr_data_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_grant_id    <= w_grant_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = ARB_CLEAR;
                end else if (w_xfer) begin
                    if (w_pick_idx == ID_W'(NUM_REQ - 1)) begin
                        w_rr_ptr_nxt = '0;
                    end else begin
                        w_rr_ptr_nxt = w_pick_idx + 1'b1;
                    end
                end
            end
            ARB_CLEAR: begin
                if (r_clr_cnt == CLR_LAST) begin
                    w_state_nxt   = ARB_IDLE;
                    w_clr_cnt_nxt = CLR_FIRST;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // The clear strobe is staged one step ahead so that while in CLEAR the
    // visible wr_en always equals one-hot(counter) alongside clear_busy.
    always_comb begin
        w_wr_en_nxt       = '0;
        w_wr_data_nxt     = r_wr_data;
        w_grant_valid_nxt = 1'b0;
        w_grant_id_nxt    = r_grant_id;
        case (r_state)
            ARB_IDLE: begin
                if (clear_req) begin
                    w_wr_en_nxt   = reg_decode(r_clr_cnt);
                    w_wr_data_nxt = '0;
                end else if (w_xfer) begin
                    w_wr_en_nxt       = reg_decode(w_win_addr);
                    w_wr_data_nxt     = w_win_data;
                    w_grant_valid_nxt = 1'b1;
                    w_grant_id_nxt    = w_pick_idx;
                end
            end
            ARB_CLEAR: begin
                if (r_clr_cnt != CLR_LAST) begin
                    w_wr_en_nxt   = reg_decode(r_clr_cnt + 1'b1);
                    w_wr_data_nxt = '0;
                end
            end
            default: begin
                w_wr_en_nxt = '0;
            end
        endcase
    end

    assign clear_busy  = (r_state == ARB_CLEAR);
    assign wr_en       = r_wr_en;
    assign wr_data     = r_wr_data;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;

`ifdef REGFILE_ARB_GRANT_COUNT_EN
    logic [15:0] r_grant_cnt [NUM_REQ];

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset) begin
                r_grant_cnt[i] <= '0;
            end else if (req_valid[i] && req_ready[i] && (r_grant_cnt[i] != 16'hFFFF)) begin
                r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_count[g*16 +: 16] = r_grant_cnt[g];
    end
`else
    // Without grant counters the transfer statistics are simply not kept.
`endif

endmodule
